sound_scheduler: RTL and testbench
==================================

# sound_scheduler

Arbitrates the game's single tone generator between several requesters, such as sequence playback, key-press feedback and win/loss signalling. It grants one request at a time by fixed priority and plays the requested sound for a requested number of cycles. It then enforces a silent gap before the next request. It drives `play`, `sound` and the `speaker` square wave, replacing ad-hoc `play`/`sound` writes in the game FSM.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters. Index 0 has the highest priority.
- `DUR_W`, 6: width of each duration field.
- `GAP_CYC`, 2: silent cycles between tones. Must be ≥1.

Ports:
- `clock`, in, 1: the single clock. Every register updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, `NUM_REQ`: request lines. Each is held high until the matching `grant` is seen.
- `req_sound`, in, `3*NUM_REQ`: sound code per requester. Field i is bits [3i+2:3i].
- `req_dur`, in, `DUR_W*NUM_REQ`: tone length minus one, per requester.
- `abort`, in, 1: cancels the current tone and gap.
- `grant`, out, `NUM_REQ`: one-hot, one-cycle pulse marking acceptance.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse when a tone completes normally.
- `play`, out, 1: tone active.
- `sound`, out, 3: latched sound code.
- `speaker`, out, 1: square-wave output.

## Operation
- Reset: state=IDLE; `grant`=0, `busy`=0, `done`=0, `play`=0, `sound`=0, `speaker`=0; all counters 0. Reset applied mid-tone produces the same values and silences the speaker on the next edge.
- IDLE: on any edge with `req`≠0 and `abort`=0, select the lowest set index w. Then:
  - latch `sound`=req_sound[w] and `count`=req_dur[w];
  - set `grant`=onehot(w) and `play`=1;
  - go to PLAY.
- If `abort`=1 while in IDLE, the edge does nothing: no accept and no output change.
- PLAY:
  - `abort`=1: go to IDLE, `play`=0, no `done`.
  - Otherwise, if `count`=0: go to GAP, `play`=0, `done`=1, `count`=GAP_CYC-1.
  - Otherwise: decrement `count`.
- GAP:
  - `abort`=1: go to IDLE.
  - Otherwise, if `count`=0: go to IDLE.
  - Otherwise: decrement `count`.
- `req` is ignored in PLAY and GAP. No preemption. Priority is fixed with no fairness; starvation of lower indices is accepted by design.
- Tone half-period, in cycles, by sound code:
  - 0 → 3, 1 → 4, 2 → 5, 3 → 6 (the colours);
  - 4 → 7 (WIN), 5 → 2 (LOSS);
  - 6 and 7 are invalid: `speaker` stays 0 while `play`=1.
- Tone generation:
  - While `play`=1 with a valid code, the phase counter counts 0…half-1. On the edge where it equals half-1, it resets to 0 and `speaker` toggles.
  - While `play`=0, the phase counter is 0 and `speaker` is 0. Every tone therefore starts with `speaker`=0 and phase 0.
- Width rules:
  - `count` is `DUR_W` bits; decrements never wrap because 0 is tested first.
  - The phase counter is 3 bits.

## Timing
- Let acceptance happen on edge T. After T, `grant` and `play` are high and `busy`=1.
- `grant` drops after edge T+1. The requester must deassert `req` in the cycle after it sees `grant`.
- `play` is high for exactly dur+1 cycles, after edges T through T+dur.
- `done` is high for one cycle, after edge T+dur+1.
- GAP lasts GAP_CYC cycles. IDLE is re-entered after edge T+dur+1+GAP_CYC.
- The earliest next acceptance is the following edge. Back-to-back tones are therefore separated by at least GAP_CYC+1 silent cycles.
- First `speaker` rise is at edge T+half. Toggles follow every `half` edges while `play`=1.
- The `abort` effect is visible after the same edge: `play`=0, `busy`=0, `speaker`=0.
- If `done` and a new `req` arrive in the same cycle, the request waits for IDLE.

## Structure
- Package `snd_pkg` holds:
  - the sound-code constants: RED=0, GREEN=1, YELLOW=2, BLUE=3, S_WIN=4, S_LOSS=5;
  - the half-period constants;
  - the state enum IDLE, PLAY, GAP.
- Sub-module `tone_gen` takes `clock`, `reset`, `play` and `sound`, and produces `speaker`. It contains the phase counter, the toggle flop and the half-period decode.
- The arbiter, duration counter and FSM live in the top module.

## Test plan
- Single tone: req[1]=1 with sound=0, dur=3.
  - `grant`=3'b010 for 1 cycle.
  - `play` high 4 cycles.
  - `speaker` rises at T+3.
  - `done` after T+4.
  - `busy` clears after T+6.
- Simultaneous requests: req[0] and req[2] both high.
  - grant[0] first.
  - grant[2] comes exactly dur0+GAP_CYC+2 edges after grant[0].
- Minimum duration: dur=0. `play` is high 1 cycle, `done` follows on the next cycle, `speaker` stays 0.
- Abort: assert `abort` 2 cycles into a dur=10 tone.
  - `play`=0 and `speaker`=0 on the next cycle.
  - No `done`.
  - A pending request is granted on the following edge.
- Invalid sound 6, dur=5: `play` high 6 cycles, `speaker` constantly 0, `done` pulses normally.
- Reset mid-tone: assert `reset` during PLAY with `speaker`=1. All outputs are 0 the next cycle, and a new `req` is accepted after `reset` drops.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared sound codes, tone half-periods and scheduler state encoding.
package snd_pkg;

   localparam int unsigned CODE_W  = 3;
   localparam int unsigned PHASE_W = 3;

   localparam logic [CODE_W-1:0] RED    = 3'd0;
   localparam logic [CODE_W-1:0] GREEN  = 3'd1;
   localparam logic [CODE_W-1:0] YELLOW = 3'd2;
   localparam logic [CODE_W-1:0] BLUE   = 3'd3;
   localparam logic [CODE_W-1:0] S_WIN  = 3'd4;
   localparam logic [CODE_W-1:0] S_LOSS = 3'd5;

   localparam logic [PHASE_W-1:0] HALF_RED    = 3'd3;
   localparam logic [PHASE_W-1:0] HALF_GREEN  = 3'd4;
   localparam logic [PHASE_W-1:0] HALF_YELLOW = 3'd5;
   localparam logic [PHASE_W-1:0] HALF_BLUE   = 3'd6;
   localparam logic [PHASE_W-1:0] HALF_WIN    = 3'd7;
   localparam logic [PHASE_W-1:0] HALF_LOSS   = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Half-period in cycles for a sound code; 0 marks an invalid (silent) code.
   function automatic logic [PHASE_W-1:0] half_period(input logic [CODE_W-1:0] code);
      logic [PHASE_W-1:0] half;
      case (code)
         RED:     half = HALF_RED;
         GREEN:   half = HALF_GREEN;
         YELLOW:  half = HALF_YELLOW;
         BLUE:    half = HALF_BLUE;
         S_WIN:   half = HALF_WIN;
         S_LOSS:  half = HALF_LOSS;
         default: half = 3'd0;
      endcase
      return half;
   endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Requester-facing bus of the sound scheduler.
interface sound_scheduler_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DUR_W   = 6
);
   logic [NUM_REQ-1:0]       req;
   logic [3*NUM_REQ-1:0]     req_sound;
   logic [DUR_W*NUM_REQ-1:0] req_dur;
   logic                     abort;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;
   logic                     done;
   logic                     play;
   logic [2:0]               sound;
   logic                     speaker;

   modport master (
      output req, req_sound, req_dur, abort,
      input  grant, busy, done, play, sound, speaker
   );

   modport slave (
      input  req, req_sound, req_dur, abort,
      output grant, busy, done, play, sound, speaker
   );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: phase counter, toggle flop and half-period decode.
// 'play' is the scheduler's next-cycle tone enable, so the speaker is
// silenced on the same edge that ends a tone; counting starts one edge
// after the tone begins so the first rise lands 'half' edges after start.
module tone_gen
   import snd_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              play,
   input  logic [CODE_W-1:0] sound,
   output logic              speaker
);

   logic [PHASE_W-1:0] r_phase;
   logic               r_run;
   logic               r_speaker;
   logic [PHASE_W-1:0] w_half;
   logic               w_valid;

   // Half-period decode of the latched sound code.
   always_comb begin
      w_half  = half_period(sound);
      w_valid = (w_half != 3'd0);
   end

   // Phase counter and speaker toggle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase   <= '0;
         r_run     <= 1'b0;
         r_speaker <= 1'b0;
      end else begin
         r_run <= play;
         if (!play || !w_valid) begin
            r_phase   <= '0;
            r_speaker <= 1'b0;
         end else if (r_run) begin
            if (r_phase == (w_half - 3'd1)) begin
               r_phase   <= '0;
               r_speaker <= ~r_speaker;
            end else begin
               r_phase <= r_phase + 3'd1;
            end
         end
      end
   end

   assign speaker = r_speaker;

endmodule

// File: rtl/sound_scheduler.sv
// Fixed-priority arbiter for the single tone generator with tone duration
// and enforced silent gap between tones.
module sound_scheduler
   import snd_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DUR_W   = 6,
   parameter int unsigned GAP_CYC = 2
) (
   input  logic             clock,
   input  logic             reset,
   sound_scheduler_if.slave bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DUR_W-1:0]    r_count;
   logic [DUR_W-1:0]    w_count_nxt;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  w_grant_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                r_play;
   logic                w_play_nxt;
   logic [CODE_W-1:0]   r_sound;
   logic [CODE_W-1:0]   w_sound_nxt;

   logic                w_any;
   logic [NUM_REQ-1:0]  w_onehot;
   logic [CODE_W-1:0]   w_sel_sound;
   logic [DUR_W-1:0]    w_sel_dur;
   logic                w_accept;
   logic                w_speaker;

   // Priority pick: lowest set request index wins.
   always_comb begin
      w_any       = 1'b0;
      w_onehot    = '0;
      w_sel_sound = '0;
      w_sel_dur   = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (bus.req[i] && !w_any) begin
            w_any       = 1'b1;
            w_onehot[i] = 1'b1;
            w_sel_sound = bus.req_sound[3*i +: 3];
            w_sel_dur   = bus.req_dur[DUR_W*i +: DUR_W];
         end
      end
   end

   assign w_accept = w_any && !bus.abort;

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_play  <= 1'b0;
         r_sound <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_grant <= w_grant_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_play  <= w_play_nxt;
         r_sound <= w_sound_nxt;
      end
   end

   // Next-state logic; abort always wins over normal progress.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = PLAY;
         PLAY: begin
            if (bus.abort)            w_state_nxt = IDLE;
            else if (r_count == '0)   w_state_nxt = GAP;
         end
         GAP:  if (bus.abort || (r_count == '0)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next values of counter and outputs.
   always_comb begin
      w_count_nxt = r_count;
      w_grant_nxt = '0;
      w_done_nxt  = 1'b0;
      w_play_nxt  = r_play;
      w_sound_nxt = r_sound;
      w_busy_nxt  = (w_state_nxt != IDLE);
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_sound_nxt = w_sel_sound;
               w_count_nxt = w_sel_dur;
               w_grant_nxt = w_onehot;
               w_play_nxt  = 1'b1;
            end
         end
         PLAY: begin
            if (bus.abort) begin
               w_play_nxt  = 1'b0;
               w_count_nxt = '0;
            end else if (r_count == '0) begin
               w_play_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_count_nxt = DUR_W'(GAP_CYC - 1);
            end else begin
               w_count_nxt = r_count - DUR_W'(1);
            end
         end
         GAP: begin
            if (bus.abort || (r_count == '0)) begin
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count - DUR_W'(1);
            end
         end
         default: begin
            w_play_nxt  = 1'b0;
            w_count_nxt = '0;
         end
      endcase
   end

   tone_gen u_tone_gen (
      .clock   (clock),
      .reset   (reset),
      .play    (w_play_nxt),
      .sound   (r_sound),
      .speaker (w_speaker)
   );

   assign bus.grant   = r_grant;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.play    = r_play;
   assign bus.sound   = r_sound;
   assign bus.speaker = w_speaker;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: directed scenarios with literal expectations,
// then random traffic checked every cycle against a tone-timeline model.
module tb_sound_scheduler;

   localparam int unsigned NR  = 3;
   localparam int unsigned DW  = 6;
   localparam int unsigned GAP = 2;

   logic clock = 1'b0;
   logic reset;

   sound_scheduler_if #(.NUM_REQ(NR), .DUR_W(DW)) bus ();

   sound_scheduler #(.NUM_REQ(NR), .DUR_W(DW), .GAP_CYC(GAP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Half-period per sound code; 0 = silent code.
   int half_tab [0:7] = '{3, 4, 5, 6, 7, 2, 0, 0};

   // Model state: one tone timeline anchored at its acceptance edge.
   bit          m_act = 1'b0;
   int          m_T = 0, m_dur = 0, m_w = 0, m_code = 0;
   logic [2:0]  m_sound = 3'd0;
   logic [NR-1:0] e_grant = '0;
   bit          e_play = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_spk = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Model update per edge: outputs as a function of cycles since acceptance.
   always @(posedge clock) begin : mdl
      int k;
      int h;
      cyc = cyc + 1;
      if (reset) begin
         m_act   = 1'b0;
         m_sound = 3'd0;
      end else if (!m_act) begin
         if (bus.req != '0 && !bus.abort) begin
            for (int i = int'(NR) - 1; i >= 0; i--) if (bus.req[i]) m_w = i;
            m_act   = 1'b1;
            m_T     = cyc;
            m_code  = int'(bus.req_sound[3*m_w +: 3]);
            m_dur   = int'(bus.req_dur[DW*m_w +: DW]);
            m_sound = 3'(m_code);
         end
      end else if (bus.abort) begin
         m_act = 1'b0;
      end
      k = cyc - m_T;
      if (m_act && k > m_dur + int'(GAP)) m_act = 1'b0;
      h = half_tab[m_code];
      e_grant = (m_act && k == 0) ? (NR'(1) << m_w) : '0;
      e_play  = m_act && (k <= m_dur);
      e_done  = m_act && (k == m_dur + 1);
      e_busy  = m_act;
      e_spk   = e_play && (h != 0) && (((k / (h == 0 ? 1 : h)) % 2) == 1);
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("grant",   32'(bus.grant),   32'(e_grant));
         chk("play",    32'(bus.play),    32'(e_play));
         chk("done",    32'(bus.done),    32'(e_done));
         chk("busy",    32'(bus.busy),    32'(e_busy));
         chk("sound",   32'(bus.sound),   32'(m_sound));
         chk("speaker", 32'(bus.speaker), 32'(e_spk));
      end
   end

   task automatic set_req(input int i, input int code, input int dur);
      bus.req_sound[3*i +: 3]  = 3'(code);
      bus.req_dur[DW*i +: DW]  = DW'(dur);
      bus.req[i]               = 1'b1;
   endtask

   task automatic wait_grant(input int i, output int t);
      t = -1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         if (bus.grant[i]) begin
            t = cyc;
            bus.req[i] = 1'b0;
            break;
         end
      end
      chk("grant_seen", 32'(t >= 0), 32'd1);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         if (!bus.busy) break;
      end
      chk("idle_reached", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int t, t0, t2, tr;
      reset         = 1'b1;
      bus.req       = '0;
      bus.req_sound = '0;
      bus.req_dur   = '0;
      bus.abort     = 1'b0;
      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      @(negedge clock);
      chk("rst_play",    32'(bus.play),    32'd0);
      chk("rst_speaker", 32'(bus.speaker), 32'd0);
      chk("rst_busy",    32'(bus.busy),    32'd0);
      reset = 1'b0;

      // Single tone: requester 1, RED, dur 3.
      set_req(1, 0, 3);
      wait_grant(1, t);
      chk("single_grant", 32'(bus.grant), 32'b010);
      chk("single_play0", 32'(bus.play),  32'd1);
      repeat (3) @(negedge clock);
      chk("single_spk_rise", 32'(bus.speaker), 32'd1);
      chk("single_play3",    32'(bus.play),    32'd1);
      @(negedge clock);
      chk("single_done", 32'(bus.done), 32'd1);
      chk("single_off",  32'(bus.play), 32'd0);
      @(negedge clock);
      chk("single_busy5", 32'(bus.busy), 32'd1);
      @(negedge clock);
      chk("single_busy6", 32'(bus.busy), 32'd0);

      // Simultaneous requests 0 and 2.
      set_req(0, 1, 2);
      set_req(2, 4, 5);
      wait_grant(0, t0);
      chk("sim_first", 32'(bus.grant), 32'b001);
      wait_grant(2, t2);
      chk("sim_spacing", 32'(t2 - t0), 32'(2 + GAP + 2));
      wait_idle();

      // Minimum duration.
      set_req(0, 1, 0);
      wait_grant(0, t);
      chk("min_play", 32'(bus.play),    32'd1);
      chk("min_spk",  32'(bus.speaker), 32'd0);
      @(negedge clock);
      chk("min_done", 32'(bus.done), 32'd1);
      chk("min_off",  32'(bus.play), 32'd0);
      wait_idle();

      // Abort two cycles into a long tone, with a request pending.
      set_req(1, 2, 10);
      wait_grant(1, t);
      @(negedge clock);
      set_req(2, 3, 1);
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      chk("abort_play", 32'(bus.play),    32'd0);
      chk("abort_spk",  32'(bus.speaker), 32'd0);
      chk("abort_busy", 32'(bus.busy),    32'd0);
      chk("abort_done", 32'(bus.done),    32'd0);
      @(negedge clock);
      chk("abort_next_grant", 32'(bus.grant), 32'b100);
      bus.req[2] = 1'b0;
      wait_idle();

      // Invalid sound code.
      set_req(0, 6, 5);
      wait_grant(0, t);
      for (int n = 0; n < 6; n++) begin
         chk("inv_play", 32'(bus.play),    32'd1);
         chk("inv_spk",  32'(bus.speaker), 32'd0);
         @(negedge clock);
      end
      chk("inv_done", 32'(bus.done), 32'd1);
      wait_idle();

      // Reset in the middle of a WIN tone while the speaker is high.
      set_req(0, 4, 30);
      wait_grant(0, t);
      repeat (8) @(negedge clock);
      chk("rst_mid_spk_hi", 32'(bus.speaker), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_mid_play",  32'(bus.play),    32'd0);
      chk("rst_mid_spk",   32'(bus.speaker), 32'd0);
      chk("rst_mid_sound", 32'(bus.sound),   32'd0);
      chk("rst_mid_busy",  32'(bus.busy),    32'd0);
      reset = 1'b0;
      set_req(1, 5, 2);
      tr = cyc;
      wait_grant(1, t);
      chk("rst_mid_accept", 32'(t - tr), 32'd1);
      wait_idle();

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         @(negedge clock);
         for (int i = 0; i < int'(NR); i++) begin
            if (bus.grant[i]) bus.req[i] = 1'b0;
            else if (!bus.req[i] && $urandom_range(0, 3) == 0)
               set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
         end
         bus.abort = ($urandom_range(0, 29) == 0);
         reset     = ($urandom_range(0, 399) == 0);
      end
      @(negedge clock);
      reset     = 1'b0;
      bus.abort = 1'b0;
      bus.req   = '0;
      wait_idle();
      repeat (2) @(negedge clock);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
